// File: rtl/seq_det_pkg.sv
// Shared defaults and match-mode encoding for the serial pattern detector.
// Imported by the detector top and its counter sub-module.
package seq_det_pkg;

   localparam int             DEF_LEN          = 3;
   localparam int             DEF_CNT_W        = 8;
   localparam logic [DEF_LEN-1:0] DEF_PATTERN_INIT = 3'b001;

   typedef enum logic {
      MATCH_NONOVERLAP = 1'b0,
      MATCH_OVERLAP    = 1'b1
   } match_mode_t;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter, clear has priority over increment; count visible one cycle after inc.
// No backpressure: inc is sampled every clock, holding at all-ones once saturated.
module seq_match_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_det.sv
// Programmable LEN-bit serial pattern detector with Mealy det (0-cycle latency) and saturating match count.
// en gates consumption (state holds when low); cfg_load takes priority over en and restarts the history fill.
module seq_pattern_det
   import seq_det_pkg::*;
#(
   parameter int             LEN          = DEF_LEN,
   parameter logic [LEN-1:0] PATTERN_INIT = LEN'(DEF_PATTERN_INIT),
   parameter int             OVERLAP      = 1,
   parameter int             CNT_W        = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             inp,
   input  logic             cfg_load,
   input  logic [LEN-1:0]   cfg_pattern,
   input  logic             cnt_clr,
   output logic             det,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int             FILL_W   = $clog2(LEN);
   localparam logic [FILL_W-1:0] FILL_ARMED = FILL_W'(LEN - 1);
   localparam bit             OVL_EN   = (match_mode_t'(OVERLAP[0]) == MATCH_OVERLAP);

   logic [LEN-1:0]    pat_q, pat_d;
   logic [LEN-2:0]    hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [LEN-1:0]    window;
   logic              accept;
   logic              det_w;

   // Candidate window: the LEN-1 stored bits followed by the bit on the wire now.
   assign window = {hist_q, inp};
   assign accept = en & ~cfg_load;
   assign det_w  = accept & (fill_q == FILL_ARMED) & (window == pat_q);

   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      if (cfg_load) begin
         pat_d  = cfg_pattern;
         fill_d = '0;
      end else if (en) begin
         hist_d = window[LEN-2:0];
         if (det_w && !OVL_EN) begin
            fill_d = '0;
         end else if (fill_q != FILL_ARMED) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q  <= PATTERN_INIT;
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

   assign det = det_w;

   seq_match_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (det_w),
      .clr   (cnt_clr),
      .cnt   (match_cnt)
   );

endmodule
